// File: rtl/mips_alu_hilo.sv
// Execute-stage integer ALU with architectural HI/LO registers.
// Mul/Div results travel through a fixed-latency pipeline into HI/LO.
module mips_alu_hilo #(
    parameter int DATA_W  = 32,
    parameter int DELAY   = 2,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data1,
    input  logic [DATA_W-1:0]  data2,
    input  logic [4:0]         func,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result,
    output logic               zero
);

    typedef enum logic [4:0] {
        OP_NONE = 5'd0,  OP_ADD  = 5'd1,  OP_ADDU = 5'd2,  OP_SUB  = 5'd3,
        OP_SUBU = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_XOR  = 5'd7,
        OP_NOR  = 5'd8,  OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_SLL  = 5'd11,
        OP_SRL  = 5'd12, OP_SRA  = 5'd13, OP_SLLV = 5'd14, OP_SRLV = 5'd15,
        OP_SRAV = 5'd16, OP_MUL  = 5'd17, OP_MULU = 5'd18, OP_DIV  = 5'd19,
        OP_DIVU = 5'd20, OP_MFHI = 5'd21, OP_MFLO = 5'd22, OP_MTHI = 5'd23,
        OP_MTLO = 5'd24
    } op_e;

    op_e                 w_op;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   w_result;
    logic [SHAMT_W-1:0]  w_vshamt;

    assign w_op     = op_e'(func);
    assign w_vshamt = data2[SHAMT_W-1:0];

    always_comb begin
        // NOTE: default assignment first so no path leaves w_result unassigned (no latch).
        w_result = '0;
        case (w_op)
            OP_ADD, OP_ADDU: w_result = data1 + data2;
            OP_SUB, OP_SUBU: w_result = data1 - data2;
            OP_AND:          w_result = data1 & data2;
            OP_OR:           w_result = data1 | data2;
            OP_XOR:          w_result = data1 ^ data2;
            OP_NOR:          w_result = ~(data1 | data2);
            OP_SLT:          w_result = {{(DATA_W-1){1'b0}}, $signed(data1) < $signed(data2)};
            OP_SLTU:         w_result = {{(DATA_W-1){1'b0}}, data1 < data2};
            OP_SLL:          w_result = data1 << shamt;
            OP_SRL:          w_result = data1 >> shamt;
            OP_SRA:          w_result = $signed(data1) >>> shamt;
            OP_SLLV:         w_result = data1 << w_vshamt;
            OP_SRLV:         w_result = data1 >> w_vshamt;
            OP_SRAV:         w_result = $signed(data1) >>> w_vshamt;
            OP_MFHI:         w_result = r_hi;
            OP_MFLO:         w_result = r_lo;
            default:         w_result = '0;
        endcase
    end

    assign result = w_result;
    assign zero   = (w_result == '0);

    // Signed mul/div operate on extended operands / magnitudes so one datapath serves both.
    logic                w_signed_op;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W-1:0]   w_b_safe;
    logic [DATA_W-1:0]   w_uquot;
    logic [DATA_W-1:0]   w_urem;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    assign w_signed_op = (w_op == OP_MUL) || (w_op == OP_DIV);
    assign w_a_neg     = w_signed_op & data1[DATA_W-1];
    assign w_b_neg     = w_signed_op & data2[DATA_W-1];
    assign w_a_ext     = {{DATA_W{w_a_neg}}, data1};
    assign w_b_ext     = {{DATA_W{w_b_neg}}, data2};
    assign w_prod      = w_a_ext * w_b_ext;
    assign w_a_mag     = w_a_neg ? -data1 : data1;
    assign w_b_mag     = w_b_neg ? -data2 : data2;
    assign w_b_safe    = (w_b_mag == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_uquot     = w_a_mag / w_b_safe;
    assign w_urem      = w_a_mag % w_b_safe;
    assign w_quot      = (w_a_neg ^ w_b_neg) ? -w_uquot : w_uquot;
    assign w_rem       = w_a_neg ? -w_urem : w_urem;

    logic              w_md_valid;
    logic [DATA_W-1:0] w_md_hi;
    logic [DATA_W-1:0] w_md_lo;

    always_comb begin
        w_md_valid = 1'b0;
        w_md_hi    = '0;
        w_md_lo    = '0;
        case (w_op)
            OP_MUL, OP_MULU: begin
                w_md_valid = 1'b1;
                w_md_hi    = w_prod[2*DATA_W-1:DATA_W];
                w_md_lo    = w_prod[DATA_W-1:0];
            end
            OP_DIV, OP_DIVU: begin
                w_md_valid = 1'b1;
                w_md_hi    = (data2 == '0) ? data1 : w_rem;
                w_md_lo    = (data2 == '0) ? '1    : w_quot;
            end
            default: ;
        endcase
    end

    logic              w_cmp_valid;
    logic [DATA_W-1:0] w_cmp_hi;
    logic [DATA_W-1:0] w_cmp_lo;

    generate
        if (DELAY == 1) begin : g_direct
            assign w_cmp_valid = w_md_valid;
            assign w_cmp_hi    = w_md_hi;
            assign w_cmp_lo    = w_md_lo;
        end else begin : g_pipe
            logic [DELAY-2:0]  r_vld;
            logic [DATA_W-1:0] r_phi [DELAY-1];
            logic [DATA_W-1:0] r_plo [DELAY-1];

            always_ff @(posedge clock) begin
                if (reset) begin
                    // NOTE: non-blocking assignments so every stage shifts from pre-edge values.
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_md_valid;
                    for (int i = 1; i < DELAY-1; i++) r_vld[i] <= r_vld[i-1];
                end
            end

            // NOTE: payload stages need no reset; the valid bits alone decide whether they are used.
            always_ff @(posedge clock) begin
                r_phi[0] <= w_md_hi;
                r_plo[0] <= w_md_lo;
                for (int i = 1; i < DELAY-1; i++) begin
                    r_phi[i] <= r_phi[i-1];
                    r_plo[i] <= r_plo[i-1];
                end
            end

            assign w_cmp_valid = r_vld[DELAY-2];
            assign w_cmp_hi    = r_phi[DELAY-2];
            assign w_cmp_lo    = r_plo[DELAY-2];
        end
    endgenerate

    // A move to HI/LO wins over a completion landing on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_op == OP_MTHI)  r_hi <= data1;
            else if (w_cmp_valid) r_hi <= w_cmp_hi;
            if (w_op == OP_MTLO)  r_lo <= data1;
            else if (w_cmp_valid) r_lo <= w_cmp_lo;
        end
    end

endmodule

// File: tb/tb_mips_alu_hilo.sv
// Self-checking bench for mips_alu_hilo: directed cases plus random ops
// against an arithmetic model of HI/LO and a queue of pending mul/div results.
module tb_mips_alu_hilo;

    localparam int DW    = 4;
    localparam int DLY   = 2;
    localparam int SW    = $clog2(DW);
    localparam int MASK  = (1 << DW) - 1;
    localparam int HALF  = 1 << (DW - 1);

    logic          clock;
    logic          reset;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [4:0]    func;
    logic [SW-1:0] shamt;
    logic [DW-1:0] result;
    logic          zero;

    mips_alu_hilo #(.DATA_W(DW), .DELAY(DLY)) dut (
        .clock  (clock),
        .reset  (reset),
        .data1  (data1),
        .data2  (data2),
        .func   (func),
        .shamt  (shamt),
        .result (result),
        .zero   (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int due;
        int hi;
        int lo;
    } pend_t;

    pend_t q[$];
    int    m_hi;
    int    m_lo;
    int    edge_n;
    int    n_checks;
    int    n_fail;
    int    last_obs;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sx(input int v);
        int t;
        t = v & MASK;
        return (t >= HALF) ? t - (1 << DW) : t;
    endfunction

    function automatic int model_result(input int f, input int a, input int b, input int s);
        int vs;
        vs = b % DW;
        case (f)
            1, 2:    return (a + b) & MASK;
            3, 4:    return (a - b) & MASK;
            5:       return a & b;
            6:       return a | b;
            7:       return a ^ b;
            8:       return ~(a | b) & MASK;
            9:       return (sx(a) < sx(b)) ? 1 : 0;
            10:      return (a < b) ? 1 : 0;
            11:      return (a << s) & MASK;
            12:      return a >> s;
            13:      return (sx(a) >>> s) & MASK;
            14:      return (a << vs) & MASK;
            15:      return a >> vs;
            16:      return (sx(a) >>> vs) & MASK;
            21:      return m_hi;
            22:      return m_lo;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input int f, input int a, input int b, input bit rst);
        pend_t p;
        int    prod;
        edge_n++;
        if (rst) begin
            m_hi = 0;
            m_lo = 0;
            q.delete();
            return;
        end
        if (f >= 17 && f <= 20) begin
            p.due = edge_n + DLY - 1;
            if (f == 17 || f == 18) begin
                prod = (f == 17) ? sx(a) * sx(b) : a * b;
                p.hi = (prod >>> DW) & MASK;
                p.lo = prod & MASK;
            end else if (b == 0) begin
                p.hi = a;
                p.lo = MASK;
            end else if (f == 19 && sx(a) == -HALF && sx(b) == -1) begin
                p.hi = 0;
                p.lo = a;
            end else if (f == 19) begin
                p.hi = (sx(a) % sx(b)) & MASK;
                p.lo = (sx(a) / sx(b)) & MASK;
            end else begin
                p.hi = a % b;
                p.lo = a / b;
            end
            q.push_back(p);
        end
        while (q.size() > 0 && q[0].due == edge_n) begin
            p = q.pop_front();
            m_hi = p.hi;
            m_lo = p.lo;
        end
        if (f == 23) m_hi = a;
        if (f == 24) m_lo = a;
    endtask

    // Present one op for a cycle, check result/zero mid-cycle, then advance the model.
    task automatic run_op(input int f, input int a, input int b, input int s);
        int exp;
        func  = 5'(f);
        data1 = DW'(a);
        data2 = DW'(b);
        shamt = SW'(s);
        @(negedge clock);
        exp      = model_result(f, a & MASK, b & MASK, s);
        last_obs = int'(result);
        check("result", last_obs, exp);
        check("zero", int'(zero), (exp == 0) ? 1 : 0);
        @(posedge clock);
        model_edge(f, a & MASK, b & MASK, reset);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_hi     = 0;
        m_lo     = 0;
        edge_n   = 0;
        reset    = 1'b1;
        func     = '0;
        data1    = '0;
        data2    = '0;
        shamt    = '0;
        @(posedge clock);
        #1;

        // Reset and basic ops
        run_op(0, 0, 0, 0);
        reset = 1'b0;
        run_op(21, 0, 0, 0);   check("mfhi_reset", last_obs, 0);
        run_op(22, 0, 0, 0);   check("mflo_reset", last_obs, 0);
        run_op(1, 7, 3, 0);    check("add_7_3", last_obs, 'hA);

        // Mulu 0xA*0xA, then Nor as filler while the product lands
        run_op(18, 'hA, 'hA, 0);
        run_op(8, 5, 3, 0);    check("nor_5_3", last_obs, 'h8);
        run_op(21, 0, 0, 0);   check("mulu_hi", last_obs, 'h6);
        run_op(22, 0, 0, 0);   check("mulu_lo", last_obs, 'h4);

        run_op(23, 'hA, 0, 0);
        run_op(21, 0, 0, 0);   check("mthi", last_obs, 'hA);
        run_op(11, 5, 0, 1);   check("sll", last_obs, 'hA);
        run_op(13, 'hA, 0, 1); check("sra", last_obs, 'hD);
        run_op(12, 'hA, 0, 2); check("srl", last_obs, 'h2);
        run_op(7, 'hF, 'hF, 0); check("xor_zero", int'(zero), 1);

        reset = 1'b1;
        run_op(0, 0, 0, 0);
        reset = 1'b0;
        run_op(21, 0, 0, 0);   check("mfhi_after_reset", last_obs, 0);

        // Divide corner cases
        run_op(19, 7, 0, 0);
        run_op(0, 0, 0, 0);
        run_op(22, 0, 0, 0);   check("div0_lo", last_obs, 'hF);
        run_op(21, 0, 0, 0);   check("div0_hi", last_obs, 'h7);
        run_op(19, 'h9, 2, 0);
        run_op(0, 0, 0, 0);
        run_op(22, 0, 0, 0);   check("div_neg_lo", last_obs, 'hD);
        run_op(21, 0, 0, 0);   check("div_neg_hi", last_obs, 'hF);
        run_op(19, 'h8, 'hF, 0);
        run_op(0, 0, 0, 0);
        run_op(22, 0, 0, 0);   check("div_ovf_lo", last_obs, 'h8);
        run_op(21, 0, 0, 0);   check("div_ovf_hi", last_obs, 'h0);

        // No interlock: Mfhi right after issue sees the old HI
        run_op(23, 5, 0, 0);
        run_op(17, 3, 3, 0);
        run_op(21, 0, 0, 0);   check("mfhi_old", last_obs, 'h5);
        run_op(22, 0, 0, 0);   check("mul_lo", last_obs, 'h9);

        // Mthi on the completing edge overrides HI only
        run_op(17, 2, 'hF, 0);
        run_op(23, 3, 0, 0);
        run_op(21, 0, 0, 0);   check("collide_hi", last_obs, 'h3);
        run_op(22, 0, 0, 0);   check("collide_lo", last_obs, 'hE);

        // Back-to-back issue
        run_op(18, 3, 3, 0);
        run_op(18, 2, 5, 0);
        run_op(22, 0, 0, 0);   check("b2b_first", last_obs, 'h9);
        run_op(22, 0, 0, 0);   check("b2b_second", last_obs, 'hA);

        // Reset between issue and completion cancels the write
        run_op(18, 3, 5, 0);
        reset = 1'b1;
        run_op(0, 0, 0, 0);
        reset = 1'b0;
        run_op(21, 0, 0, 0);   check("cancel_hi", last_obs, 0);
        run_op(22, 0, 0, 0);   check("cancel_lo", last_obs, 0);

        // Random traffic against the model
        repeat (800) begin
            reset = ($urandom_range(0, 59) == 0);
            run_op($urandom_range(0, 31), $urandom_range(0, MASK),
                   $urandom_range(0, MASK), $urandom_range(0, DW - 1));
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
